// File: rtl/lcd_bus_pkg.sv
// Shared constants, instruction classes and address-counter helpers for the
// HD44780-style bus responder.
package lcd_bus_pkg;

  // Instruction class is chosen by the highest set bit of the opcode
  localparam int INS_CLEAR_BIT = 0;
  localparam int INS_HOME_BIT  = 1;
  localparam int INS_ENTRY_BIT = 2;
  localparam int INS_DISP_BIT  = 3;
  localparam int INS_SHIFT_BIT = 4;
  localparam int INS_FUNC_BIT  = 5;
  localparam int INS_CGRAM_BIT = 6;
  localparam int INS_DDRAM_BIT = 7;

  localparam logic [7:0] SPACE_CHAR = 8'h20;
  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE_END   = 7'h27;
  localparam logic [6:0] LINE2_END  = 7'h67;

  localparam int BUS_W      = 11;
  localparam int BUS_E_BIT  = 10;
  localparam int BUS_RS_BIT = 9;
  localparam int BUS_RW_BIT = 8;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_CLEAR,
    CLS_HOME,
    CLS_ENTRY,
    CLS_DISP,
    CLS_SHIFT,
    CLS_FUNC,
    CLS_CGRAM,
    CLS_DDRAM
  } ins_class_e;

  function automatic ins_class_e ins_class(input logic [7:0] d);
    ins_class_e c;
    if (d[INS_DDRAM_BIT])      c = CLS_DDRAM;
    else if (d[INS_CGRAM_BIT]) c = CLS_CGRAM;
    else if (d[INS_FUNC_BIT])  c = CLS_FUNC;
    else if (d[INS_SHIFT_BIT]) c = CLS_SHIFT;
    else if (d[INS_DISP_BIT])  c = CLS_DISP;
    else if (d[INS_ENTRY_BIT]) c = CLS_ENTRY;
    else if (d[INS_HOME_BIT])  c = CLS_HOME;
    else if (d[INS_CLEAR_BIT]) c = CLS_CLEAR;
    else                       c = CLS_NOP;
    return c;
  endfunction

  // Two-line DDRAM map: line 1 ends at 0x27 and jumps to 0x40, line 2 ends at 0x67
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] n;
    if (inc) begin
      if (ac == LINE_END)       n = LINE2_BASE;
      else if (ac == LINE2_END) n = LINE1_BASE;
      else                      n = ac + 7'd1;
    end else begin
      if (ac == LINE2_BASE)      n = LINE_END;
      else if (ac == LINE1_BASE) n = LINE2_END;
      else                       n = ac - 7'd1;
    end
    return n;
  endfunction

  function automatic logic ac_visible(input logic [6:0] ac);
    return (ac[5:4] == 2'b00);
  endfunction

  function automatic logic [4:0] buf_index(input logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchroniser for the LCD bus plus one-cycle E falling-edge strobe;
// RS/RW/DATA are presented as captured one cycle before the fall.
module lcd_bus_sync
  import lcd_bus_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_e,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic [7:0] i_data,
  output logic       o_evt,
  output logic       o_e_sync,
  output logic       o_rs_sync,
  output logic       o_rw_sync,
  output logic       o_rs,
  output logic       o_rw,
  output logic [7:0] o_data
);

  logic [BUS_W-1:0] r_meta;
  logic [BUS_W-1:0] r_sync;
  logic [BUS_W-1:0] r_prev;

  // Metastability chain followed by the previous-cycle copy used for sampling
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= {BUS_W{1'b0}};
      r_sync <= {BUS_W{1'b0}};
      r_prev <= {BUS_W{1'b0}};
    end else begin
      r_meta <= {i_e, i_rs, i_rw, i_data};
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_evt     = r_prev[BUS_E_BIT] & ~r_sync[BUS_E_BIT];
  assign o_e_sync  = r_sync[BUS_E_BIT];
  assign o_rs_sync = r_sync[BUS_RS_BIT];
  assign o_rw_sync = r_sync[BUS_RW_BIT];
  assign o_rs      = r_prev[BUS_RS_BIT];
  assign o_rw      = r_prev[BUS_RW_BIT];
  assign o_data    = r_prev[7:0];

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style bus responder: 2x16 display mirror, controller state and busy
// emulation. Define LCD_BUSY_READ_EN to answer busy-flag and data reads.
module lcd_bus_responder
  import lcd_bus_pkg::*;
#(
  parameter int CMD_CYCLES   = 40,
  parameter int CLEAR_CYCLES = 1640,
  parameter int LINE_LEN     = 16
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  output logic [7:0] RD_DATA_OUT,
  output logic       RD_OE,
  output logic       BUSY,
  input  logic [4:0] RAM_RADDR,
  output logic [7:0] RAM_RDATA,
  output logic       DISP_ON,
  output logic       CURSOR_ON,
  output logic [6:0] AC,
  output logic       ERR_BUSY,
  output logic       UPDATE
);

  localparam int NUM_CHARS = 2 * LINE_LEN;
  localparam int MAX_CYC   = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
  localparam int CNT_W     = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

  // The {line, column[3:0]} buffer index only works for 16-character lines
  generate
    if (LINE_LEN != 16) begin : g_line_len_check
      $error("lcd_bus_responder: LINE_LEN must be 16");
    end
  endgenerate

  logic       w_evt;
  logic       w_e_sync;
  logic       w_rs_sync;
  logic       w_rw_sync;
  logic       w_rs;
  logic       w_rw;
  logic [7:0] w_data;
  logic [4:0] w_buf_idx;
  logic       w_cfg_unused;
  ins_class_e w_cls;

  logic [7:0]       r_buf [NUM_CHARS];
  logic [6:0]       r_ac;
  logic             r_id;
  logic             r_s;
  logic             r_disp_on;
  logic             r_cursor_on;
  logic             r_blink;
  logic             r_n;
  logic             r_busy;
  logic [CNT_W-1:0] r_busy_cnt;
  logic             r_err_busy;
  logic             r_update;
  logic [7:0]       r_ram_rdata;

  lcd_bus_sync u_sync (
    .i_clk     (CLK),
    .i_rst_n   (RESETN),
    .i_e       (LCD_E),
    .i_rs      (LCD_RS),
    .i_rw      (LCD_RW),
    .i_data    (LCD_DATA),
    .o_evt     (w_evt),
    .o_e_sync  (w_e_sync),
    .o_rs_sync (w_rs_sync),
    .o_rw_sync (w_rw_sync),
    .o_rs      (w_rs),
    .o_rw      (w_rw),
    .o_data    (w_data)
  );

  assign w_cls     = ins_class(w_data);
  assign w_buf_idx = buf_index(r_ac);

  // Transaction execution, busy countdown and the display buffer
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < NUM_CHARS; i++) r_buf[i] <= SPACE_CHAR;
      r_ac        <= LINE1_BASE;
      r_id        <= 1'b1;
      r_s         <= 1'b0;
      r_disp_on   <= 1'b0;
      r_cursor_on <= 1'b0;
      r_blink     <= 1'b0;
      r_n         <= 1'b0;
      r_busy      <= 1'b0;
      r_busy_cnt  <= {CNT_W{1'b0}};
      r_err_busy  <= 1'b0;
      r_update    <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (r_busy) begin
        if (r_busy_cnt == {CNT_W{1'b0}}) r_busy <= 1'b0;
        else                             r_busy_cnt <= r_busy_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_evt) begin
        if (w_rw) begin
`ifdef LCD_BUSY_READ_EN
          if (w_rs) r_ac <= ac_step(r_ac, r_id);
`endif
        end else if (r_busy) begin
          r_err_busy <= 1'b1;
        end else begin
          r_busy     <= 1'b1;
          r_busy_cnt <= CMD_LOAD;
          if (w_rs) begin
            if (ac_visible(r_ac)) begin
              r_buf[w_buf_idx] <= w_data;
              r_update         <= 1'b1;
            end
            r_ac <= ac_step(r_ac, r_id);
          end else begin
            case (w_cls)
              CLS_CLEAR: begin
                for (int i = 0; i < NUM_CHARS; i++) r_buf[i] <= SPACE_CHAR;
                r_ac       <= LINE1_BASE;
                r_id       <= 1'b1;
                r_update   <= 1'b1;
                r_busy_cnt <= CLEAR_LOAD;
              end
              CLS_HOME: begin
                r_ac       <= LINE1_BASE;
                r_busy_cnt <= CLEAR_LOAD;
              end
              CLS_ENTRY: begin
                r_id <= w_data[1];
                r_s  <= w_data[0];
              end
              CLS_DISP: begin
                r_disp_on   <= w_data[2];
                r_cursor_on <= w_data[1];
                r_blink     <= w_data[0];
              end
              CLS_SHIFT: begin
                if (!w_data[3]) r_ac <= ac_step(r_ac, w_data[2]);
              end
              CLS_FUNC:  r_n  <= w_data[3];
              CLS_DDRAM: r_ac <= w_data[6:0];
              default: ;
            endcase
          end
        end
      end
    end
  end

  // Registered read port; a same-cycle write is seen one cycle later
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_ram_rdata <= SPACE_CHAR;
    else         r_ram_rdata <= r_buf[RAM_RADDR];
  end

`ifdef LCD_BUSY_READ_EN
  logic       r_rd_oe;
  logic [7:0] r_rd_data;

  // Drive the bus for the E-high phase of a read; release one cycle after the fall
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_rd_oe   <= 1'b0;
      r_rd_data <= 8'h00;
    end else if (w_e_sync && w_rw_sync) begin
      r_rd_oe <= 1'b1;
      if (!w_rs_sync)             r_rd_data <= {r_busy, r_ac};
      else if (ac_visible(r_ac))  r_rd_data <= r_buf[w_buf_idx];
      else                        r_rd_data <= SPACE_CHAR;
    end else begin
      r_rd_oe   <= 1'b0;
      r_rd_data <= 8'h00;
    end
  end

  assign RD_OE        = r_rd_oe;
  assign RD_DATA_OUT  = r_rd_data;
  assign w_cfg_unused = ^{r_s, r_blink, r_n};
`else
  assign RD_OE        = 1'b0;
  assign RD_DATA_OUT  = 8'h00;
  assign w_cfg_unused = ^{r_s, r_blink, r_n, w_e_sync, w_rs_sync, w_rw_sync};
`endif

  assign BUSY      = r_busy;
  assign RAM_RDATA = r_ram_rdata;
  assign DISP_ON   = r_disp_on;
  assign CURSOR_ON = r_cursor_on;
  assign AC        = r_ac;
  assign ERR_BUSY  = r_err_busy;
  assign UPDATE    = r_update;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder: table of bus writes with a
// scoreboard queue, plus hand sequences for busy, clear, reset and reads.
`timescale 1ns/1ps
module tb_lcd_bus_responder;

  localparam int CMD = 40;
  localparam int CLR = 1640;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] raddr = 5'd0;
  logic [7:0] rd_data_out;
  logic       rd_oe;
  logic       busy;
  logic [7:0] ram_rdata;
  logic       disp_on;
  logic       cursor_on;
  logic [6:0] ac;
  logic       err_busy;
  logic       update;

  lcd_bus_responder dut (
    .CLK(clk), .RESETN(rst_n), .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw),
    .LCD_DATA(lcd_data), .RD_DATA_OUT(rd_data_out), .RD_OE(rd_oe), .BUSY(busy),
    .RAM_RADDR(raddr), .RAM_RDATA(ram_rdata), .DISP_ON(disp_on),
    .CURSOR_ON(cursor_on), .AC(ac), .ERR_BUSY(err_busy), .UPDATE(update)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [6:0] exp_ac;
    int         exp_upd;
    logic       chk_dc;
    logic       exp_disp;
    logic       exp_cur;
    int         exp_busy;
  } vec_t;

  vec_t exp_q[$];
  vec_t tab[27];
  int   n_pass = 0;
  int   n_total = 0;
  bit   ok;
  int   len, upd;
  logic [7:0] rb;
  logic       p_oe;
  logic [7:0] p_dat;

  function automatic vec_t mk(input logic rs, input logic [7:0] d, input logic [6:0] a,
                              input int u, input logic chk, input logic dsp,
                              input logic cur, input int b);
    vec_t v;
    v.rs = rs; v.data = d; v.exp_ac = a; v.exp_upd = u;
    v.chk_dc = chk; v.exp_disp = dsp; v.exp_cur = cur; v.exp_busy = b;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_txn(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (5) @(negedge clk);
    lcd_e = 1'b0;
  endtask

  task automatic wait_rise(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic measure_busy(output int n, output int u);
    n = 0; u = 0;
    while (busy && n < 4000) begin
      n++;
      if (update) u++;
      @(negedge clk);
    end
  endtask

  task automatic read_buf(input logic [4:0] idx, output logic [7:0] d);
    @(negedge clk);
    raddr = idx;
    @(negedge clk);
    d = ram_rdata;
  endtask

  task automatic read_probe(input logic rs, output logic oe, output logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
    repeat (5) @(negedge clk);
    oe = rd_oe; d = rd_data_out;
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    check("rd_oe_release", 32'(rd_oe), 32'd0);
    lcd_rw = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    bit   got;
    int   n, u;
    exp_q.push_back(v);
    drive_txn(v.rs, 1'b0, v.data);
    wait_rise(got);
    e = exp_q.pop_front();
    if (!got) begin
      check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    end else begin
      check({tag, "_ac"}, 32'(ac), 32'(e.exp_ac));
      if (e.chk_dc) begin
        check({tag, "_disp"}, 32'(disp_on), 32'(e.exp_disp));
        check({tag, "_cursor"}, 32'(cursor_on), 32'(e.exp_cur));
      end
      measure_busy(n, u);
      check({tag, "_busy_len"}, 32'(n), 32'(e.exp_busy));
      check({tag, "_update"}, 32'(u), 32'(e.exp_upd));
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0]  = mk(1'b0, 8'h80, 7'h00, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[1]  = mk(1'b1, 8'h41, 7'h01, 1, 1'b1, 1'b0, 1'b0, CMD);
    tab[2]  = mk(1'b0, 8'hC0, 7'h40, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[3]  = mk(1'b1, 8'h31, 7'h41, 1, 1'b1, 1'b0, 1'b0, CMD);
    tab[4]  = mk(1'b1, 8'h32, 7'h42, 1, 1'b1, 1'b0, 1'b0, CMD);
    tab[5]  = mk(1'b0, 8'hA7, 7'h27, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[6]  = mk(1'b1, 8'h55, 7'h40, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[7]  = mk(1'b0, 8'h04, 7'h40, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[8]  = mk(1'b1, 8'h77, 7'h27, 1, 1'b1, 1'b0, 1'b0, CMD);
    tab[9]  = mk(1'b1, 8'h66, 7'h26, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[10] = mk(1'b0, 8'h14, 7'h27, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[11] = mk(1'b0, 8'h10, 7'h26, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[12] = mk(1'b0, 8'h1C, 7'h26, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[13] = mk(1'b0, 8'h06, 7'h26, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[14] = mk(1'b0, 8'hE7, 7'h67, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[15] = mk(1'b1, 8'h58, 7'h00, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[16] = mk(1'b0, 8'h0E, 7'h00, 0, 1'b1, 1'b1, 1'b1, CMD);
    tab[17] = mk(1'b0, 8'h0A, 7'h00, 0, 1'b1, 1'b0, 1'b1, CMD);
    tab[18] = mk(1'b0, 8'h38, 7'h00, 0, 1'b1, 1'b0, 1'b1, CMD);
    tab[19] = mk(1'b0, 8'h40, 7'h00, 0, 1'b1, 1'b0, 1'b1, CMD);
    tab[20] = mk(1'b0, 8'h85, 7'h05, 0, 1'b1, 1'b0, 1'b1, CMD);
    tab[21] = mk(1'b0, 8'h02, 7'h00, 0, 1'b1, 1'b0, 1'b1, CLR);
    tab[22] = mk(1'b0, 8'h08, 7'h00, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[23] = mk(1'b0, 8'h04, 7'h00, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[24] = mk(1'b0, 8'h10, 7'h67, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[25] = mk(1'b0, 8'h14, 7'h00, 0, 1'b1, 1'b0, 1'b0, CMD);
    tab[26] = mk(1'b0, 8'h06, 7'h00, 0, 1'b1, 1'b0, 1'b0, CMD);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_busy), 32'd0);
    check("rst_ac", 32'(ac), 32'd0);
    check("rst_disp", 32'(disp_on), 32'd0);
    check("rst_cursor", 32'(cursor_on), 32'd0);
    check("rst_update", 32'(update), 32'd0);
    check("rst_rd_oe", 32'(rd_oe), 32'd0);
    check("rst_rd_data", 32'(rd_data_out), 32'd0);
    check("rst_ram_rdata", 32'(ram_rdata), 32'h20);
    rst_n = 1'b1;
    read_buf(5'd31, rb);
    check("rst_buf31", 32'(rb), 32'h20);

    // Table-driven writes
    for (int i = 0; i < 5; i++) run_vec(tab[i], $sformatf("vec%0d", i));
    read_buf(5'd0, rb);  check("buf0_A", 32'(rb), 32'h41);
    read_buf(5'd16, rb); check("buf16_31", 32'(rb), 32'h31);
    read_buf(5'd17, rb); check("buf17_32", 32'(rb), 32'h32);
    for (int i = 5; i < 27; i++) run_vec(tab[i], $sformatf("vec%0d", i));
    read_buf(5'd16, rb); check("buf16_77", 32'(rb), 32'h77);
    read_buf(5'd17, rb); check("buf17_kept", 32'(rb), 32'h32);
    read_buf(5'd0, rb);  check("buf0_kept", 32'(rb), 32'h41);

    // Write issued while busy is dropped and flagged
    run_vec(mk(1'b0, 8'h85, 7'h05, 0, 1'b0, 1'b0, 1'b0, CMD), "set_ac5");
    check("err_before", 32'(err_busy), 32'd0);
    drive_txn(1'b1, 1'b0, 8'h5A);
    wait_rise(ok);
    check("err_first_rise", 32'(busy), 32'd1);
    fork
      measure_busy(len, upd);
      begin
        repeat (10) @(negedge clk);
        drive_txn(1'b1, 1'b0, 8'h5B);
      end
    join
    check("err_busy_len", 32'(len), 32'(CMD));
    check("err_update", 32'(upd), 32'd1);
    check("err_flag", 32'(err_busy), 32'd1);
    check("err_ac", 32'(ac), 32'h06);
    read_buf(5'd5, rb); check("err_buf5", 32'(rb), 32'h5A);
    read_buf(5'd6, rb); check("err_buf6", 32'(rb), 32'h20);

    // Fill both lines, then clear
    run_vec(mk(1'b0, 8'h80, 7'h00, 0, 1'b0, 1'b0, 1'b0, CMD), "fill_home1");
    for (int i = 0; i < 16; i++)
      run_vec(mk(1'b1, 8'(8'h30 + i), 7'(i + 1), 1, 1'b0, 1'b0, 1'b0, CMD), "fill1");
    run_vec(mk(1'b0, 8'hC0, 7'h40, 0, 1'b0, 1'b0, 1'b0, CMD), "fill_home2");
    for (int i = 0; i < 16; i++)
      run_vec(mk(1'b1, 8'(8'h50 + i), 7'(7'h41 + i), 1, 1'b0, 1'b0, 1'b0, CMD), "fill2");
    read_buf(5'd0, rb);  check("fill_buf0", 32'(rb), 32'h30);
    read_buf(5'd15, rb); check("fill_buf15", 32'(rb), 32'h3F);
    read_buf(5'd16, rb); check("fill_buf16", 32'(rb), 32'h50);
    read_buf(5'd31, rb); check("fill_buf31", 32'(rb), 32'h5F);
    run_vec(mk(1'b0, 8'h04, 7'h50, 0, 1'b0, 1'b0, 1'b0, CMD), "entry_dec");
    run_vec(mk(1'b0, 8'h01, 7'h00, 1, 1'b0, 1'b0, 1'b0, CLR), "clear");
    for (int i = 0; i < 32; i++) begin
      read_buf(5'(i), rb);
      check($sformatf("clear_buf%0d", i), 32'(rb), 32'h20);
    end
    run_vec(mk(1'b1, 8'h41, 7'h01, 1, 1'b0, 1'b0, 1'b0, CMD), "post_clear_inc");
    check("err_sticky", 32'(err_busy), 32'd1);

    // Reset in the middle of a clear window
    drive_txn(1'b0, 1'b0, 8'h01);
    wait_rise(ok);
    check("clr2_rise", 32'(busy), 32'd1);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err", 32'(err_busy), 32'd0);
    check("midrst_ac", 32'(ac), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_busy_after", 32'(busy), 32'd0);

    // Read transactions
    drive_txn(1'b0, 1'b0, 8'h85);
    wait_rise(ok);
    check("rd_setup_rise", 32'(busy), 32'd1);
    read_probe(1'b0, p_oe, p_dat);
`ifdef LCD_BUSY_READ_EN
    check("bf_read_busy_oe", 32'(p_oe), 32'd1);
    check("bf_read_busy_data", 32'(p_dat), 32'h85);
`else
    check("bf_read_busy_oe", 32'(p_oe), 32'd0);
    check("bf_read_busy_data", 32'(p_dat), 32'h00);
`endif
    measure_busy(len, upd);
    read_probe(1'b0, p_oe, p_dat);
`ifdef LCD_BUSY_READ_EN
    check("bf_read_idle_data", 32'(p_dat), 32'h05);
`else
    check("bf_read_idle_data", 32'(p_dat), 32'h00);
`endif
    read_probe(1'b1, p_oe, p_dat);
    repeat (12) @(negedge clk);
`ifdef LCD_BUSY_READ_EN
    check("data_read_val", 32'(p_dat), 32'h20);
    check("data_read_ac", 32'(ac), 32'h06);
`else
    check("data_read_val", 32'(p_dat), 32'h00);
    check("data_read_ac", 32'(ac), 32'h05);
`endif
    check("read_no_busy", 32'(busy), 32'd0);
    check("read_no_err", 32'(err_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
